sram_burst_ctrl: RTL and testbench

Burst access controller that sits directly upstream of the 2048x32 SRAM macro wrapper and drives its CEB/WEB/A/D pins. It accepts one burst command at a time (write or read, base address, length), streams write data into the SRAM and returns read data on a valid/ready stream. It absorbs the macro's 1-cycle read latency with a 2-entry skid FIFO, so reads run at full throughput under arbitrary backpressure.

---
 rtl/sram_burst_ctrl_pkg.sv | 20 ++
 rtl/sram_burst_ctrl_if.sv | 40 ++++
 rtl/sram_rd_skid_fifo.sv | 38 +++
 rtl/sram_burst_ctrl.sv | 108 ++++++++++
 tb/tb_sram_burst_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and sizing for the SRAM burst controller and its read skid FIFO.
package sram_burst_ctrl_pkg;

  localparam int num_word      = 2048;
  localparam int num_bit       = 32;
  localparam int num_word_addr = $clog2(num_word);

  // Two entries cover the one-cycle macro read latency plus one held word.
  localparam int fifo_depth = 2;
  localparam int fifo_cnt_w = $clog2(fifo_depth + 1);
  localparam int fifo_ptr_w = $clog2(fifo_depth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Command, write-data and read-data streams between a burst master and the controller.
// Handshake rule for all three streams: a transfer happens on the rising clock edge
// where valid && ready are both 1; the sender holds its payload stable while valid is
// high, and ready never depends combinationally on valid.
interface sram_burst_ctrl_if;
  import sram_burst_ctrl_pkg::*;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [num_word_addr-1:0] cmd_addr;
  logic [num_word_addr-1:0] cmd_len;

  logic                     wr_valid;
  logic                     wr_ready;
  logic [num_bit-1:0]       wr_data;

  logic                     rd_valid;
  logic                     rd_ready;
  logic [num_bit-1:0]       rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready
  );

endinterface

// File: rtl/sram_rd_skid_fifo.sv
// Two-entry register FIFO catching SRAM read data so reads survive backpressure.
module sram_rd_skid_fifo
  import sram_burst_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [num_bit-1:0]    din,
  output logic [fifo_cnt_w-1:0] count,
  output logic [num_bit-1:0]    head
);

  logic [num_bit-1:0]    mem [fifo_depth];
  logic [fifo_ptr_w-1:0] wr_ptr;
  logic [fifo_ptr_w-1:0] rd_ptr;

  // Storage: data words carry no reset, only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO synchronously.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + fifo_ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr + fifo_ptr_w'(1);
      count <= count + fifo_cnt_w'(push) - fifo_cnt_w'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller driving the 2048x32 SRAM macro pins: write bursts stream straight
// to the macro, read bursts return through a skid FIFO that hides the read latency.
module sram_burst_ctrl
  import sram_burst_ctrl_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RST,
  sram_burst_ctrl_if.slave         bus,
  output logic                     busy,
  output logic                     CEB,
  output logic                     WEB,
  output logic [num_word_addr-1:0] A,
  output logic [num_bit-1:0]       D,
  input  logic [num_bit-1:0]       Q,
  output state_t                   dbg_state
);

  state_t                   state;
  logic [num_word_addr-1:0] addr;
  logic [num_word_addr-1:0] cnt;
  logic [num_word_addr-1:0] a_q;
  logic [num_bit-1:0]       d_q;
  logic                     inflight;

  logic [fifo_cnt_w-1:0]    fifo_count;
  logic [num_bit-1:0]       fifo_head;
  logic                     pop;
  logic                     wr_beat;
  logic                     rd_issue;
  logic [2:0]               occ;

  // Words held or still coming back from the macro once this cycle's pop is taken out.
  assign pop      = bus.rd_valid && bus.rd_ready;
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_issue = (state == READ) && (occ < 3'(fifo_depth));
  assign wr_beat  = (state == WRITE) && bus.wr_valid;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WRITE);
  assign bus.rd_valid  = (fifo_count != '0);
  assign bus.rd_data   = fifo_head;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  // Macro pins: active only on an access, otherwise deselected with A/D parked.
  assign CEB = !(wr_beat || rd_issue);
  assign WEB = !wr_beat;
  assign A   = (wr_beat || rd_issue) ? addr : a_q;
  assign D   = wr_beat ? bus.wr_data : d_q;

  // Burst FSM with address/count tracking, read-inflight flag and parked pin values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
    end else begin
      inflight <= rd_issue;
      if (wr_beat || rd_issue) a_q <= addr;
      if (wr_beat)             d_q <= bus.wr_data;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr  <= bus.cmd_addr;
            cnt   <= bus.cmd_len;
            state <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            addr <= addr + num_word_addr'(1);
            cnt  <= cnt - num_word_addr'(1);
            if (cnt == '0) state <= IDLE;
          end
        end
        READ: begin
          if (rd_issue) begin
            addr <= addr + num_word_addr'(1);
            cnt  <= cnt - num_word_addr'(1);
            if (cnt == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave once nothing is in flight and the last buffered word is leaving.
          if (!inflight && ((fifo_count == '0) ||
                            ((fifo_count == fifo_cnt_w'(1)) && pop)))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Q is valid the cycle after a read issue; that is the only time it is captured.
  sram_rd_skid_fifo u_fifo (
    .clk   (CLK),
    .flush (RST),
    .push  (inflight),
    .pop   (pop),
    .din   (Q),
    .count (fifo_count),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: SRAM macro model, access/read monitors, directed and
// randomized bursts checked against a reference memory and expected-data queue.
module tb_sram_burst_ctrl;
  import sram_burst_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_burst_ctrl_if bus ();
  logic         busy, CEB, WEB;
  logic [10:0]  A;
  logic [31:0]  D, Q;
  state_t       dbg_state;

  sram_burst_ctrl dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .busy      (busy),
    .CEB       (CEB),
    .WEB       (WEB),
    .A         (A),
    .D         (D),
    .Q         (Q),
    .dbg_state (dbg_state)
  );

  // SRAM macro model: one-cycle read latency
  logic [31:0] sram [num_word];
  always @(posedge clk) begin
    if (CEB === 1'b0) begin
      if (WEB === 1'b0) sram[A] <= D;
      else              Q <= sram[A];
    end
  end

  // ---------------- monitors ----------------
  typedef struct { logic web; logic [10:0] a; logic [31:0] d; int c; } acc_t;
  typedef struct { logic [31:0] d; int c; } rd_t;
  acc_t acc_log[$];
  rd_t  rd_log[$];
  int   out_n = 0;
  int   max_out = 0;

  always @(negedge clk) begin
    #2;
    if (CEB === 1'b0) acc_log.push_back('{WEB, A, D, cyc});
    if (rst === 1'b1) out_n = 0;
    else begin
      if (CEB === 1'b0 && WEB === 1'b1) out_n++;
      if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
        rd_log.push_back('{bus.rd_data, cyc});
        out_n--;
      end
      if (out_n > max_out) max_out = out_n;
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [31:0] ref_mem [num_word];
  logic [31:0] exp_q[$];
  logic [31:0] wbuf [16];
  int total = 0;
  int bad = 0;
  int acc_cyc, acc_base, rd_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic send_cmd(input logic w, input logic [10:0] a, input logic [10:0] l);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    #1;
    while (bus.cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    check("cmd_accept_in_time", 32'(guard < 200), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 11'($urandom);
    bus.cmd_len   = 11'($urandom);
    acc_cyc  = cyc;
    acc_base = acc_log.size();
    rd_base  = rd_log.size();
  endtask

  task automatic write_beats(input int n, input int gap_at, input int gap_len, input bit rnd);
    int sent = 0;
    int idle = 0;
    int guard = 0;
    logic v;
    while (sent < n && guard < 1000) begin
      v = 1'b1;
      if (rnd) v = ($urandom_range(0, 3) != 0);
      if (sent == gap_at && idle < gap_len) begin v = 1'b0; idle++; end
      bus.wr_valid = v;
      bus.wr_data  = wbuf[sent];
      #1;
      if (v && bus.wr_ready === 1'b1) sent++;
      @(negedge clk);
      guard++;
    end
    bus.wr_valid = 1'b0;
    check("write_done_in_time", 32'(guard < 1000), 32'd1);
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready low in cycles 3..8 after accept
  task automatic read_beats(input int n, input int mode);
    int got = 0;
    int guard = 0;
    int rel;
    while (got < n && guard < 1000) begin
      rel = cyc - acc_cyc + 1;
      case (mode)
        1:       bus.rd_ready = ($urandom_range(0, 3) != 0);
        2:       bus.rd_ready = !(rel >= 3 && rel <= 8);
        default: bus.rd_ready = 1'b1;
      endcase
      #1;
      if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) got++;
      @(negedge clk);
      guard++;
    end
    bus.rd_ready = 1'b1;
    check("read_done_in_time", 32'(guard < 1000), 32'd1);
  endtask

  task automatic fill_write(input logic [10:0] base, input int n, input bit rnd_data, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      wbuf[i] = rnd_data ? $urandom : seed + 32'(i);
      ref_mem[11'(base + 11'(i))] = wbuf[i];
    end
  endtask

  task automatic expect_read(input logic [10:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[11'(base + 11'(i))]);
  endtask

  task automatic score_read(input string tag, input int n);
    logic [31:0] e;
    check({tag, "_beats"}, 32'(rd_log.size() - rd_base), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (rd_base + i < rd_log.size()) check({tag, "_data"}, rd_log[rd_base + i].d, e);
    end
  endtask

  function automatic int count_acc(input int rel_lo, input int rel_hi);
    int k = 0;
    int rel;
    for (int i = acc_base; i < acc_log.size(); i++) begin
      rel = acc_log[i].c - acc_cyc + 1;
      if (rel >= rel_lo && rel <= rel_hi) k++;
    end
    return k;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  logic [10:0] base;
  int          len;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0;  bus.wr_data = '0;     bus.rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
    check("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_ceb",       32'(CEB),           32'd1);
    check("rst_web",       32'(WEB),           32'd1);
    check("rst_a",         32'(A),             32'd0);
    check("rst_d",         D,                  32'd0);
    check("rst_state",     32'(dbg_state),     32'(IDLE));
    @(negedge clk);

    // Wrapping write burst 0x7FE..0x001, data A0..A3, continuous wr_valid
    fill_write(11'h7FE, 4, 1'b0, 32'hA0);
    send_cmd(1'b1, 11'h7FE, 11'd3);
    write_beats(4, -1, 0, 1'b0);
    #1;
    check("wr_cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
    check("wr_acc_count", 32'(acc_log.size() - acc_base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (acc_base + i < acc_log.size()) begin
        check("wr_web",   32'(acc_log[acc_base + i].web), 32'd0);
        check("wr_addr",  32'(acc_log[acc_base + i].a),  32'(11'(11'h7FE + 11'(i))));
        check("wr_data",  acc_log[acc_base + i].d,        32'hA0 + 32'(i));
        check("wr_cycle", 32'(acc_log[acc_base + i].c - acc_cyc), 32'(i));
      end
    end
    @(negedge clk);

    // Read the same burst back with rd_ready held high
    expect_read(11'h7FE, 4);
    send_cmd(1'b0, 11'h7FE, 11'd3);
    read_beats(4, 0);
    #1;
    check("rd_cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
    check("rd_acc_count", 32'(acc_log.size() - acc_base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (rd_base + i < rd_log.size())
        check("rd_beat_cycle", 32'(rd_log[rd_base + i].c - acc_cyc + 1), 32'(3 + i));
    end
    score_read("rd_wrap", 4);
    @(negedge clk);

    // Random write of 8 words, then read with rd_ready low in cycles 3..8
    base = 11'($urandom);
    fill_write(base, 8, 1'b1, 32'd0);
    send_cmd(1'b1, base, 11'd7);
    write_beats(8, -1, 0, 1'b1);
    @(negedge clk);
    expect_read(base, 8);
    send_cmd(1'b0, base, 11'd7);
    read_beats(8, 2);
    check("stall_no_issue", 32'(count_acc(3, 8)), 32'd0);
    check("stall_acc_count", 32'(acc_log.size() - acc_base), 32'd8);
    check("stall_max_outstanding", 32'(max_out <= 2), 32'd1);
    score_read("rd_stall", 8);
    @(negedge clk);

    // Write of 3 words with a 2-cycle wr_valid gap after the first beat
    base = 11'($urandom);
    fill_write(base, 3, 1'b1, 32'd0);
    send_cmd(1'b1, base, 11'd2);
    write_beats(3, 1, 2, 1'b0);
    check("gap_acc_count", 32'(acc_log.size() - acc_base), 32'd3);
    check("gap_idle_cycles", 32'(count_acc(2, 3)), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (acc_base + i < acc_log.size())
        check("gap_addr", 32'(acc_log[acc_base + i].a), 32'(11'(base + 11'(i))));
    end
    @(negedge clk);

    // Single-word read
    expect_read(base, 1);
    send_cmd(1'b0, base, 11'd0);
    read_beats(1, 0);
    #1;
    check("len0_acc_count", 32'(acc_log.size() - acc_base), 32'd1);
    check("len0_idle", 32'(bus.cmd_ready), 32'd1);
    score_read("rd_len0", 1);
    @(negedge clk);

    // Reset during a read after two issues
    send_cmd(1'b0, 11'h7FE, 11'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ceb",       32'(CEB),           32'd1);
    check("mid_rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    check("mid_rst_busy",      32'(busy),          32'd0);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    #1;
    check("mid_rst_no_stale_push", 32'(bus.rd_valid), 32'd0);
    check("mid_rst_acc_count", 32'(acc_log.size() - acc_base), 32'd2);
    check("mid_rst_no_beats", 32'(rd_log.size() - rd_base), 32'd0);
    @(negedge clk);

    // Recovery read after reset
    expect_read(11'h7FE, 4);
    send_cmd(1'b0, 11'h7FE, 11'd3);
    read_beats(4, 1);
    score_read("rd_after_rst", 4);
    @(negedge clk);

    // Randomized write/read bursts with random gaps and backpressure
    for (int t = 0; t < 6; t++) begin
      base = 11'($urandom);
      len  = $urandom_range(0, 15);
      fill_write(base, len + 1, 1'b1, 32'd0);
      send_cmd(1'b1, base, 11'(len));
      write_beats(len + 1, -1, 0, 1'b1);
      @(negedge clk);
      expect_read(base, len + 1);
      send_cmd(1'b0, base, 11'(len));
      read_beats(len + 1, 1);
      check("rnd_rd_acc_count", 32'(acc_log.size() - acc_base), 32'(len + 1));
      score_read("rd_rnd", len + 1);
      @(negedge clk);
    end

    check("final_max_outstanding", 32'(max_out <= 2), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
